// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: control states and the
// next-PC source select used by the top-level datapath mux.
package pc_pkg;

    // Control states of the PC sequencer.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Source of the PC value loaded at the next clock edge.
    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_SEQ  = 3'd1,
        SEL_BR   = 3'd2,
        SEL_RAS  = 3'd3,
        SEL_TRAP = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a circular buffer of DEPTH entries (power of two).
// A push onto a full stack overwrites the oldest entry; the occupancy count
// saturates at DEPTH. A simultaneous push and pop replaces the top entry so
// the occupancy is unchanged. Entry storage is deliberately not reset; only
// the pointer and occupancy count are.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;       // next write slot
    logic [CW-1:0]    r_cnt;       // valid entries, saturating at DEPTH
    logic [AW-1:0]    w_top_idx;   // slot holding the most recent push
    logic             w_pop_ok;

    assign w_top_idx = r_ptr - AW'(1'b1);
    assign w_pop_ok  = i_pop && (r_cnt != '0);
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_top     = r_mem[w_top_idx];

    // Entry storage: a push+pop pair rewrites the top slot in place.
    always_ff @(posedge clk) begin
        if (i_push) begin
            if (w_pop_ok) begin
                r_mem[w_top_idx] <= i_data;
            end else begin
                r_mem[r_ptr] <= i_data;
            end
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            case ({i_push, w_pop_ok})
                2'b10: begin
                    r_ptr <= r_ptr + AW'(1'b1);
                    if (r_cnt != CW'(DEPTH)) begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                2'b01: begin
                    r_ptr <= w_top_idx;
                    r_cnt <= r_cnt - CW'(1'b1);
                end
                default: begin
                    r_ptr <= r_ptr;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT sequencer with sequential stepping,
// optional wrap-to-reset, branches, traps and halt/resume.
// Optional feature macro: PC_RAS_EN builds the return-address stack
// (call pushes, ret pops). Without it, call is a plain branch, ret is
// ignored and ras_err stays low.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter logic [WIDTH-1:0] STEP       = WIDTH'(32'd4),
    parameter logic [WIDTH-1:0] WRAP_LIMIT = '0,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_ready,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call,
    input  logic             ret,
    input  logic             trap,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc_out,
    output logic             pc_valid,
    output logic             ras_err
);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    pc_sel_e          w_sel;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_seq_sum;
    logic [WIDTH-1:0] w_seq_pc;
    logic             r_valid;
    logic             r_ras_err;
    logic             w_ras_err_nxt;
    logic             w_adv;
    logic             w_push;
    logic             w_pop;
    logic             w_call_en;
    logic             w_ret_en;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_empty;

    // Plain sum is the return address; the wrapped value is the fetch step.
    assign w_seq_sum = r_pc + STEP;
    assign w_seq_pc  = ((WRAP_LIMIT != '0) && (w_seq_sum == WRAP_LIMIT)) ? RESET_VEC : w_seq_sum;
    assign w_adv     = (r_state == RUN) && pc_ready && !stall;

`ifdef PC_RAS_EN
    assign w_call_en = call;
    assign w_ret_en  = ret;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_seq_sum),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  ()
    );
`else
    logic w_unused_ras;

    assign w_call_en    = 1'b0;
    assign w_ret_en     = 1'b0;
    assign w_ras_top    = '0;
    assign w_ras_empty  = 1'b1;
    assign w_unused_ras = ^{ret, call, w_push, w_pop};
`endif

    // Next state, next-PC source, stack control and underflow flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel         = SEL_HOLD;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_ras_err_nxt = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (trap) begin
                    w_sel       = SEL_TRAP;
                    w_state_nxt = RUN;
                end else begin
                    if (w_adv) begin
                        if (w_ret_en && !w_ras_empty) begin
                            w_sel  = SEL_RAS;
                            w_pop  = 1'b1;
                            w_push = br_valid && w_call_en;
                        end else if (br_valid) begin
                            w_sel  = SEL_BR;
                            w_push = w_call_en;
                        end else begin
                            w_sel = SEL_SEQ;
                        end
                        w_ras_err_nxt = w_ret_en && w_ras_empty;
                    end else begin
                        w_sel = SEL_HOLD;
                    end
                    if (halt_req) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            HALT: begin
                if (trap) begin
                    w_sel       = SEL_TRAP;
                    w_state_nxt = RUN;
                end else if (resume) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = HALT;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // Next-PC multiplexer.
    always_comb begin
        w_pc_nxt = r_pc;
        case (w_sel)
            SEL_SEQ:  w_pc_nxt = w_seq_pc;
            SEL_BR:   w_pc_nxt = br_target;
            SEL_RAS:  w_pc_nxt = w_ras_top;
            SEL_TRAP: w_pc_nxt = trap_vec;
            default:  w_pc_nxt = r_pc;
        endcase
    end

    // State, PC and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BOOT;
            r_pc      <= RESET_VEC;
            r_valid   <= 1'b0;
            r_ras_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_valid   <= (w_state_nxt == RUN);
            r_ras_err <= w_ras_err_nxt;
        end
    end

    assign pc_out   = r_pc;
    assign pc_valid = r_valid;
    assign ras_err  = r_ras_err;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances sharing stimulus.
//   A: RESET_VEC=0x100, no wrap, RAS_DEPTH=2
//   B: RESET_VEC=0,     WRAP_LIMIT=0x10, RAS_DEPTH=4
// A rule-level model tracks both; a negedge process compares every cycle,
// and directed literal checks pin the model.
module tb_pc_unit;

`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pc_ready = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_vec = 32'h80;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;

    logic [31:0] pc_a, pc_b;
    logic        val_a, val_b, err_a, err_b;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // model state per instance: mode 0=boot 1=run 2=halt; stack oldest..newest
    int          m_mode [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_stk  [2][4];
    int          m_cnt  [2];
    bit          m_err  [2];

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .RESET_VEC(32'h100), .STEP(32'h4), .WRAP_LIMIT(32'h0), .RAS_DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .pc_ready(pc_ready), .stall(stall), .br_valid(br_valid),
        .br_target(br_target), .call(call), .ret(ret), .trap(trap), .trap_vec(trap_vec),
        .halt_req(halt_req), .resume(resume), .pc_out(pc_a), .pc_valid(val_a), .ras_err(err_a));

    pc_unit #(.WIDTH(32), .RESET_VEC(32'h0), .STEP(32'h4), .WRAP_LIMIT(32'h10), .RAS_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .pc_ready(pc_ready), .stall(stall), .br_valid(br_valid),
        .br_target(br_target), .call(call), .ret(ret), .trap(trap), .trap_vec(trap_vec),
        .halt_req(halt_req), .resume(resume), .pc_out(pc_b), .pc_valid(val_b), .ras_err(err_b));

    function automatic logic [31:0] p_rv(input int k);
        return (k == 0) ? 32'h100 : 32'h0;
    endfunction

    function automatic logic [31:0] p_wrap(input int k);
        return (k == 0) ? 32'h0 : 32'h10;
    endfunction

    function automatic int p_depth(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_mode[k] = 0;
        m_pc[k]   = p_rv(k);
        m_cnt[k]  = 0;
        m_err[k]  = 1'b0;
    endtask

    task automatic model_push(input int k, input logic [31:0] v);
        if (m_cnt[k] == p_depth(k)) begin
            for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
            m_stk[k][p_depth(k)-1] = v;
        end else begin
            m_stk[k][m_cnt[k]] = v;
            m_cnt[k]++;
        end
    endtask

    // One clock edge of the architectural rules for instance k.
    task automatic model_step(input int k);
        logic [31:0] sum, seq, popped;
        m_err[k] = 1'b0;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        sum = m_pc[k] + 32'h4;
        seq = (p_wrap(k) != 32'h0 && sum == p_wrap(k)) ? p_rv(k) : sum;
        if (m_mode[k] == 0) begin
            m_mode[k] = 1;
        end else if (trap) begin
            m_pc[k]   = trap_vec;
            m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
            if (pc_ready && !stall) begin
                if (RAS && ret && m_cnt[k] > 0) begin
                    popped = m_stk[k][m_cnt[k]-1];
                    m_cnt[k]--;
                    if (br_valid && call) model_push(k, sum);
                    m_pc[k] = popped;
                end else begin
                    if (RAS && ret) m_err[k] = 1'b1;
                    if (br_valid) begin
                        if (RAS && call) model_push(k, sum);
                        m_pc[k] = br_target;
                    end else begin
                        m_pc[k] = seq;
                    end
                end
            end
            if (halt_req) m_mode[k] = 2;
        end else begin
            if (resume) m_mode[k] = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("A.pc_out",   pc_a,       m_pc[0]);
            check("A.pc_valid", 32'(val_a), 32'(m_mode[0] == 1));
            check("A.ras_err",  32'(err_a), 32'(m_err[0]));
            check("B.pc_out",   pc_b,       m_pc[1]);
            check("B.pc_valid", 32'(val_b), 32'(m_mode[1] == 1));
            check("B.ras_err",  32'(err_b), 32'(m_err[1]));
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        chk_en = 1'b1;
        tick();
        tick();
        check("lit reset A.pc", pc_a, 32'h100);
        check("lit reset A.valid", 32'(val_a), 32'h0);
        check("lit reset B.pc", pc_b, 32'h0);

        // boot cycle, then sequential stepping and wrap on B
        rst_n = 1'b1;
        tick();
        check("lit boot A.valid", 32'(val_a), 32'h1);
        check("lit boot A.pc", pc_a, 32'h100);
        check("lit boot B.pc", pc_b, 32'h0);
        tick();
        check("lit seq A 104", pc_a, 32'h104);
        check("lit seq B 4", pc_b, 32'h4);
        tick();
        check("lit seq A 108", pc_a, 32'h108);
        check("lit seq B 8", pc_b, 32'h8);
        tick();
        check("lit seq B C", pc_b, 32'hC);
        tick();
        check("lit wrap B 0", pc_b, 32'h0);
        check("lit nowrap A 110", pc_a, 32'h110);

        // stall at 0x20 for three cycles, trap in the second
        br_valid = 1'b1; br_target = 32'h20;
        tick();
        br_valid = 1'b0; stall = 1'b1;
        tick();
        check("lit stall hold", pc_a, 32'h20);
        trap = 1'b1;
        tick();
        check("lit trap under stall", pc_a, 32'h80);
        trap = 1'b0;
        tick();
        check("lit trap hold", pc_b, 32'h80);
        stall = 1'b0;

        // halt at 0x30, resume
        br_valid = 1'b1; br_target = 32'h30;
        tick();
        br_valid = 1'b0; halt_req = 1'b1;
        tick();
        check("lit halt pc", pc_a, 32'h34);
        check("lit halt valid", 32'(val_a), 32'h0);
        halt_req = 1'b0;
        tick();
        tick();
        check("lit halt hold", pc_a, 32'h34);
        resume = 1'b1;
        tick();
        check("lit resume pc", pc_a, 32'h34);
        check("lit resume valid", 32'(val_a), 32'h1);
        resume = 1'b0;
        tick();
        check("lit resume step", pc_a, 32'h38);

        // call at 0x40 to 0x200, return at 0x208
        br_valid = 1'b1; br_target = 32'h40;
        tick();
        call = 1'b1; br_target = 32'h200;
        tick();
        check("lit call target", pc_a, 32'h200);
        br_valid = 1'b0; call = 1'b0;
        tick();
        tick();
        check("lit before ret", pc_a, 32'h208);
        ret = 1'b1;
        tick();
        check("lit ret", pc_a, RAS ? 32'h44 : 32'h20C);
        ret = 1'b0;

        // three calls, four returns
        br_valid = 1'b1; call = 1'b1;
        br_target = 32'h300; tick();
        br_target = 32'h400; tick();
        br_target = 32'h500; tick();
        br_valid = 1'b0; call = 1'b0; ret = 1'b1;
        tick();
        check("lit ret1 A", pc_a, RAS ? 32'h404 : 32'h504);
        tick();
        check("lit ret2 A", pc_a, RAS ? 32'h304 : 32'h508);
        tick();
        check("lit ret3 A", pc_a, RAS ? 32'h308 : 32'h50C);
        check("lit ret3 A err", 32'(err_a), 32'(RAS));
        check("lit ret3 B", pc_b, RAS ? 32'h48 : 32'h50C);
        tick();
        check("lit ret4 A", pc_a, RAS ? 32'h30C : 32'h510);
        check("lit ret4 B err", 32'(err_b), 32'(RAS));
        ret = 1'b0;
        tick();
        check("lit err one cycle", 32'(err_a), 32'h0);

        // simultaneous call and ret
        br_valid = 1'b1; call = 1'b1; br_target = 32'h600;
        tick();
        ret = 1'b1; br_target = 32'h700;
        tick();
        check("lit call+ret", pc_a, RAS ? 32'h314 : 32'h700);
        br_valid = 1'b0; call = 1'b0;
        tick();
        check("lit ret after swap", pc_a, RAS ? 32'h604 : 32'h704);
        tick();
        ret = 1'b0;

        // trap out of HALT
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; trap = 1'b1;
        tick();
        check("lit trap from halt", pc_a, 32'h80);
        check("lit trap from halt valid", 32'(val_a), 32'h1);
        trap = 1'b0;
        tick();

        // reset dropped mid-halt
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #2 rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check("lit async reset A.pc", pc_a, 32'h100);
        check("lit async reset A.valid", 32'(val_a), 32'h0);
        check("lit async reset B.pc", pc_b, 32'h0);
        tick();
        rst_n = 1'b1;

        // halt_req and trap ignored in BOOT
        halt_req = 1'b1; trap = 1'b1;
        tick();
        halt_req = 1'b0; trap = 1'b0;
        check("lit boot ignores trap", pc_a, 32'h100);
        check("lit boot ignores halt", 32'(val_a), 32'h1);
        tick();
        check("lit after boot step", pc_a, 32'h104);
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits.
REQ-002 Parameter RESET_VEC, default 0: PC value after reset.
REQ-003 Parameter STEP, default 4: sequential increment.
REQ-004 Parameter WRAP_LIMIT, default 0: a sequential next-PC equal to this value loads RESET_VEC instead; 0 disables the check.
REQ-005 Parameter RAS_DEPTH, default 4: return-address stack entries, power of two, minimum 2.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 pc_ready  in  1  fetch accepts pc_out this cycle.
REQ-009 stall  in  1  freeze PC advance.
REQ-010 br_valid  in  1  redirect to br_target.
REQ-011 br_target  in  WIDTH  branch/call target.
REQ-012 call  in  1  qualifies br_valid as a call; pushes the return address.
REQ-013 ret  in  1  pop the return-address stack into PC.
REQ-014 trap  in  1  redirect to trap_vec; highest priority.
REQ-015 trap_vec  in  WIDTH  trap handler address.
REQ-016 halt_req / resume  in  1 each  enter / leave HALT.
REQ-017 pc_out  out  WIDTH  current PC.
REQ-018 pc_valid  out  1  pc_out is presented for fetch.
REQ-019 ras_err  out  1  one-cycle pulse on stack underflow.

Function
REQ-020 States BOOT, RUN, HALT; reset enters BOOT; BOOT moves to RUN after exactly one cycle.
REQ-021 pc_valid is 1 only in RUN.
REQ-022 Advance condition in RUN: pc_valid && pc_ready && !stall; otherwise pc_out holds.
REQ-023 trap updates PC at the next edge in any state except BOOT, regardless of stall or pc_ready, and forces RUN.
REQ-024 Next-PC priority when advancing: ret (non-empty stack) > br_valid > sequential.
REQ-025 Sequential next-PC is (pc_out + STEP) mod 2^WIDTH, and equals RESET_VEC if WRAP_LIMIT != 0 and the sum equals WRAP_LIMIT.
REQ-026 br_valid && call pushes (pc_out + STEP) mod 2^WIDTH and loads br_target.
REQ-027 ret on an empty stack takes the sequential path and pulses ras_err for one cycle.
REQ-028 Push on a full stack overwrites the oldest entry (circular); the depth count saturates at RAS_DEPTH.
REQ-029 Simultaneous call and ret: pop first, then push, so the stack depth is unchanged and PC takes the popped value.
REQ-030 halt_req in RUN completes any advance in the same cycle, then enters HALT; pc_out holds in HALT.
REQ-031 resume in HALT returns to RUN at the held pc_out.
REQ-032 halt_req and resume are ignored in BOOT.

Reset
REQ-033 Asserting rst_n low immediately sets pc_out=RESET_VEC, pc_valid=0, ras_err=0, stack depth 0 and state BOOT, including mid-operation.
REQ-034 Stack entry contents are not reset; only the depth and pointer are reset.

Configuration
REQ-035 With PC_RAS_EN defined, the return-address stack is built and behaves as REQ-026 to REQ-029.
REQ-036 Without PC_RAS_EN, no stack storage exists, call behaves as a plain branch, ret is ignored, and ras_err is tied to 0.

Structure
REQ-037 Package pc_pkg holds the state enum (BOOT, RUN, HALT) and the next-PC select encoding.
REQ-038 The stack is sub-module pc_ras (push, pop, top, empty, full), instantiated only under PC_RAS_EN.

Verification
REQ-039 Reset with RESET_VEC=0x100 and pc_ready=1: pc_valid=0 for 1 cycle, then pc_out steps 0x100, 0x104, 0x108.
REQ-040 WRAP_LIMIT=0x10, STEP=4, RESET_VEC=0: pc_out sequence is 0x0, 0x4, 0x8, 0xC, 0x0.
REQ-041 stall held 3 cycles at pc_out 0x20 with a trap at cycle 2 (trap_vec=0x80): pc_out becomes 0x80 on the next edge.
REQ-042 PC_RAS_EN: call at 0x40 to 0x200, then ret at 0x208: pc_out goes 0x200, then 0x44.
REQ-043 PC_RAS_EN, RAS_DEPTH=2: three calls then four rets: the first two rets return to the last two return addresses, and the third and fourth each pulse ras_err with the sequential path taken.
REQ-044 halt_req at 0x30 with pc_ready=1: pc_out=0x34 and pc_valid=0 until resume, then advancing resumes from 0x34; rst_n dropped mid-halt: pc_out=RESET_VEC immediately.
